led_blink_arbiter: RTL and testbench

Shares a single status LED between NUM_REQ requesters. Each requester asks for the LED with a blink code N. The block grants requesters in round-robin order and plays N ON/OFF blinks followed by an inter-code gap. It then signals completion and releases the LED. It sits between the status sources (error, link, activity flags) and the board LED pin, and replaces direct free-running blinkers.

---
 rtl/led_arb_pkg.sv | 25 ++
 rtl/led_tick_gen.sv | 31 +++
 rtl/led_blink_arbiter.sv | 161 ++++++++++++++++
 tb/tb_led_blink_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and default constants for the LED blink arbiter.
package led_arb_pkg;

  // Arbiter sequence states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ON   = 3'd1,
    OFF  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } led_state_e;

  localparam int NUM_REQ_DEF     = 4;
  localparam int CNT_W_DEF       = 4;
  localparam int TICK_CYCLES_DEF = 25_000_000;
  localparam int GAP_TICKS_DEF   = 2;

  // Width of the phase counter; it must reach the longest phase (the gap).
  function automatic int phase_w(input int gap_ticks, input int tick_cycles);
    int w;
    w = $clog2(gap_ticks * tick_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Phase counter for the LED arbiter: counts up or down from a start value
// after a synchronous clear and flags the terminal count combinationally.
// The counter holds at the terminal value until cleared again.
module led_tick_gen #(
  parameter int W        = 4,
  parameter bit COUNT_UP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] start,
  input  logic [W-1:0] stop,
  output logic         tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == stop);

  // Phase count: reload on clear, otherwise step toward the stop value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= start;
    end else if (!tc) begin
      cnt <= COUNT_UP ? (cnt + W'(1)) : (cnt - W'(1));
    end
  end

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing one active-low status LED between NUM_REQ
// requesters. The winner's blink code N is played as N ON/OFF pairs
// followed by a dark gap, then a one-cycle done pulse releases the LED.
// Optional build macro LED_ARB_HEARTBEAT_EN: while idle, led_n toggles
// every TICK_CYCLES cycles as a liveness heartbeat; without it the LED
// stays dark whenever no grant is active.
module led_blink_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int GAP_TICKS   = GAP_TICKS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] code,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     done,
  output logic                     busy,
  output logic                     led_n
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PH_W  = phase_w(GAP_TICKS, TICK_CYCLES);
  localparam logic [PH_W-1:0] TICK_LIM = PH_W'(TICK_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LIM  = PH_W'(GAP_TICKS * TICK_CYCLES - 1);

  // First requester strictly after ptr, wrapping around; returns ptr when
  // nothing is requested (the caller only uses it when some req is set).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && r[IDX_W'(idx)]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  led_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   win;
  logic [CNT_W-1:0]   win_code;
  logic [CNT_W-1:0]   remaining_q;
  logic               arb;
  logic [NUM_REQ-1:0] grant_d;
  logic               led_d, done_d, busy_d;
  logic               ph_clr, ph_tc;
  logic [PH_W-1:0]    ph_stop;

  assign win = rr_pick(req, rr_q);
  assign arb = (state_q == IDLE) && (|req);

  // Select the winning requester's code field.
  always_comb begin
    win_code = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win) win_code = code[i*CNT_W +: CNT_W];
    end
  end

  // Terminal count of the phase that is currently running.
  always_comb begin
    case (state_q)
      GAP:     ph_stop = GAP_LIM;
      DONE:    ph_stop = '0;
      default: ph_stop = TICK_LIM;
    endcase
  end

  // Every state change restarts the phase so each phase has exact length.
  // In idle the counter either free-runs for the heartbeat or stays parked.
`ifdef LED_ARB_HEARTBEAT_EN
  assign ph_clr = (state_d != state_q) || ((state_q == IDLE) && ph_tc);
`else
  assign ph_clr = (state_d != state_q) || (state_q == IDLE);
`endif

  led_tick_gen #(
    .W        (PH_W),
    .COUNT_UP (1'b1)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ph_clr),
    .start ({PH_W{1'b0}}),
    .stop  (ph_stop),
    .tc    (ph_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: arbitrate in idle, then walk the blink sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (|req) state_d = (win_code != '0) ? ON : DONE;
      ON:   if (ph_tc) state_d = OFF;
      OFF:  if (ph_tc) state_d = (remaining_q > CNT_W'(1)) ? ON : GAP;
      GAP:  if (ph_tc) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    grant_d = grant;
    if (state_d == IDLE)  grant_d = '0;
    else if (arb)         grant_d = NUM_REQ'(1) << win;
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    led_d   = 1'b1;
    if (state_d == ON) begin
      led_d = 1'b0;
    end
`ifdef LED_ARB_HEARTBEAT_EN
    else if ((state_d == IDLE) && (state_q == IDLE)) begin
      led_d = ph_tc ? ~led_n : led_n;
    end
`endif
  end

  // Registered outputs and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      led_n <= 1'b1;
      rr_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      grant <= grant_d;
      done  <= done_d;
      busy  <= busy_d;
      led_n <= led_d;
      if (arb) rr_q <= win;
    end
  end

  // Blink count: latched at grant, decremented at the end of each OFF phase.
  always_ff @(posedge clk) begin
    if (arb)                        remaining_q <= win_code;
    else if ((state_q == OFF) && ph_tc) remaining_q <= remaining_q - CNT_W'(1);
  end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter: directed scenarios plus random requesters,
// compared every cycle against a waveform-level reference model.
module tb_led_blink_arbiter;

  localparam int NR = 4;
  localparam int CW = 4;
  localparam int TC = 4;
  localparam int GT = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*CW-1:0] code = '0;
  logic [NR-1:0]   grant;
  logic            done, busy, led_n;

  led_blink_arbiter #(
    .NUM_REQ(NR), .CNT_W(CW), .TICK_CYCLES(TC), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code),
    .grant(grant), .done(done), .busy(busy), .led_n(led_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: on each grant the whole expected output waveform is
  // expanded from the blink code into a queue of per-cycle beats.
  typedef struct packed {
    logic [NR-1:0] g;
    logic          led;
    logic          dn;
  } beat_t;

  beat_t         beats[$];
  logic [NR-1:0] exp_grant;
  logic          exp_led, exp_done, exp_busy;
  int            m_rr;
  int            m_win, m_n;
  logic [NR-1:0] m_g;
  beat_t         m_b;
  bit            chk_en = 1'b0;
`ifdef LED_ARB_HEARTBEAT_EN
  logic          hb_led, nx_hb_led;
  int            hb_cnt, nx_hb_cnt;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats.delete();
      exp_grant <= '0;
      exp_led   <= 1'b1;
      exp_done  <= 1'b0;
      exp_busy  <= 1'b0;
      m_rr      <= NR - 1;
`ifdef LED_ARB_HEARTBEAT_EN
      hb_led    <= 1'b1;
      hb_cnt    <= 0;
`endif
    end else begin
      if (!exp_busy && (req != '0)) begin
        m_win = -1;
        for (int k = 1; k <= NR; k++)
          if (m_win < 0 && req[(m_rr + k) % NR]) m_win = (m_rr + k) % NR;
        m_rr <= m_win;
        m_n  = int'(code[m_win*CW +: CW]);
        m_g  = NR'(1) << m_win;
        for (int b = 0; b < m_n; b++) begin
          for (int t = 0; t < TC; t++) beats.push_back(beat_t'{g: m_g, led: 1'b0, dn: 1'b0});
          for (int t = 0; t < TC; t++) beats.push_back(beat_t'{g: m_g, led: 1'b1, dn: 1'b0});
        end
        if (m_n > 0)
          for (int t = 0; t < GT*TC; t++) beats.push_back(beat_t'{g: m_g, led: 1'b1, dn: 1'b0});
        beats.push_back(beat_t'{g: m_g, led: 1'b1, dn: 1'b1});
      end
      if (beats.size() > 0) begin
        m_b = beats.pop_front();
        exp_grant <= m_b.g;
        exp_led   <= m_b.led;
        exp_done  <= m_b.dn;
        exp_busy  <= 1'b1;
      end else begin
        exp_grant <= '0;
        exp_done  <= 1'b0;
        exp_busy  <= 1'b0;
`ifdef LED_ARB_HEARTBEAT_EN
        if (exp_busy) begin
          nx_hb_led = 1'b1;
          nx_hb_cnt = 0;
        end else begin
          nx_hb_led = hb_led;
          nx_hb_cnt = hb_cnt + 1;
          if (nx_hb_cnt == TC) begin
            nx_hb_led = ~hb_led;
            nx_hb_cnt = 0;
          end
        end
        hb_led  <= nx_hb_led;
        hb_cnt  <= nx_hb_cnt;
        exp_led <= nx_hb_led;
`else
        exp_led <= 1'b1;
`endif
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check_val("grant", 32'(grant), 32'(exp_grant));
      check_val("led_n", 32'(led_n), 32'(exp_led));
      check_val("done",  32'(done),  32'(exp_done));
      check_val("busy",  32'(busy),  32'(exp_busy));
    end
  end

  task automatic wait_grant(output bit ok, output int idle);
    ok = 1'b0;
    idle = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (grant != '0) ok = 1'b1;
      else idle++;
    end
  endtask

  task automatic count_grant(input int start_len, output int len, output int done_at,
                             output int dcnt);
    bit fin;
    fin     = 1'b0;
    len     = start_len;
    done_at = done ? start_len : 0;
    dcnt    = done ? 1 : 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      if (grant == '0) fin = 1'b1;
      else begin
        len++;
        if (done) begin
          done_at = len;
          dcnt++;
        end
      end
    end
  endtask

  task automatic settle();
    req = '0;
    repeat (60) @(negedge clk);
  endtask

  bit            ok;
  int            idle, len, done_at, dcnt;
  logic [NR-1:0] order [5];

  initial begin
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check_val("rst_led_n", 32'(led_n), 32'd1);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_done",  32'(done),  32'd0);
    check_val("rst_busy",  32'(busy),  32'd0);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Idle for 50 cycles with no request.
    repeat (50) @(negedge clk);
    check_val("idle_busy", 32'(busy), 32'd0);

    // All four requesting code 1: round-robin order, 17-cycle grants, 1 idle cycle.
    code = 16'h1111;
    req  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_grant(ok, idle);
      check_val("rr_seen", 32'(ok), 32'd1);
      check_val("rr_order", 32'(grant), 32'(order[i]));
      if (i > 0) check_val("rr_gap", 32'(1 + idle), 32'd1);
      if (i == 4) req = '0;
      count_grant(1, len, done_at, dcnt);
      check_val("rr_len", 32'(len), 32'd17);
    end
    settle();

    // Single requester, code 2: 25-cycle grant with done in the last cycle.
    code[3:0] = 4'd2;
    req = 4'b0001;
    wait_grant(ok, idle);
    check_val("c2_seen", 32'(ok), 32'd1);
    req = '0;
    count_grant(1, len, done_at, dcnt);
    check_val("c2_len", 32'(len), 32'd25);
    check_val("c2_done_at", 32'(done_at), 32'd25);
    check_val("c2_done_cnt", 32'(dcnt), 32'd1);
    settle();

    // Code 0: one cycle of grant together with done.
    code[11:8] = 4'd0;
    req = 4'b0100;
    wait_grant(ok, idle);
    check_val("c0_seen", 32'(ok), 32'd1);
    req = '0;
    count_grant(1, len, done_at, dcnt);
    check_val("c0_len", 32'(len), 32'd1);
    check_val("c0_done_at", 32'(done_at), 32'd1);
    settle();

    // Code 3, then req dropped and code changed two cycles in.
    code[7:4] = 4'd3;
    req = 4'b0010;
    wait_grant(ok, idle);
    check_val("c3_seen", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    #1 req = '0;
    code[7:4] = 4'd1;
    count_grant(3, len, done_at, dcnt);
    check_val("c3_len", 32'(len), 32'd33);
    check_val("c3_done_at", 32'(done_at), 32'd33);
    settle();

    // Asynchronous reset during the second ON phase.
    code[3:0] = 4'd2;
    req = 4'b0001;
    wait_grant(ok, idle);
    req = '0;
    repeat (9) @(negedge clk);
    check_val("mr_on", 32'(led_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("mr_led_n", 32'(led_n), 32'd1);
    check_val("mr_grant", 32'(grant), 32'd0);
    check_val("mr_busy",  32'(busy),  32'd0);
    check_val("mr_done",  32'(done),  32'd0);
    repeat (2) @(negedge clk);
    #1;
    code[3:0] = 4'd1;
    code[7:4] = 4'd1;
    req = 4'b0011;
    rst_n = 1'b1;
    wait_grant(ok, idle);
    check_val("mr_first", 32'(grant), 32'b0001);
    req[0] = 1'b0;
    count_grant(1, len, done_at, dcnt);
    wait_grant(ok, idle);
    check_val("mr_second", 32'(grant), 32'b0010);
    settle();

    // Random well-behaved requesters.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (exp_done && exp_grant[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else code[i*CW +: CW] = CW'($urandom_range(3, 0));
        end else if (exp_grant[i]) begin
          if ($urandom_range(15, 0) == 0) req[i] = 1'b0;
          if ($urandom_range(7, 0) == 0) code[i*CW +: CW] = CW'($urandom_range(15, 0));
        end else if (!req[i]) begin
          if ($urandom_range(7, 0) == 0) begin
            code[i*CW +: CW] = CW'($urandom_range(3, 0));
            req[i] = 1'b1;
          end
        end
      end
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
